instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Sequences the instruction memory (256 x 32-bit words, asynchronous read, word index = address/4).
//  Owns the PC, drives the memory address, and captures each fetched word with its PC into a small queue.
//  Presents instructions to decode over a valid/ready handshake.
//  Handles branch/jump redirects and flags misaligned or out-of-range fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; must be word aligned
//  MEM_BYTES   1024           byte size of instruction memory; fetch_pc >= MEM_BYTES is out of range
//  QUEUE_DEPTH 2              fetch queue entries; power of two, >= 2
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  imem_addr      out  32  byte address to instruction memory (= fetch_pc, combinational from register)
//  imem_data      in   32  instruction word returned combinationally for imem_addr
//  redirect_valid in   1   branch/jump taken this cycle
//  redirect_pc    in   32  target byte address
//  inst_valid     out  1   queue head holds a valid instruction
//  inst_ready     in   1   decode accepts head this cycle
//  inst_out       out  32  head instruction word; 0 when !inst_valid
//  inst_pc        out  32  PC of head instruction; 0 when !inst_valid
//  fault          out  1   sticky: misaligned redirect or fetch past MEM_BYTES
// BEHAVIOUR
//  Reset values: fetch_pc=RESET_PC; queue count=0; pointers=0; fault=0.
//  Output reset values: inst_valid=0, inst_out=0, inst_pc=0, imem_addr=RESET_PC.
//  Reset mid-operation discards all queued entries on that edge.
//  pop  = inst_valid & inst_ready.
//  push = !fault & !redirect_valid & (fetch_pc < MEM_BYTES) & (count < QUEUE_DEPTH | pop).
//  On push: enqueue {fetch_pc, imem_data}; fetch_pc <= fetch_pc + 4.
//  Full with simultaneous pop: push proceeds, count unchanged.
//  Latency: first cycle after rst deasserts, RESET_PC is fetched; inst_valid=1 the following cycle.
//  Sustained throughput is one instruction per cycle while inst_ready=1.
//  Ordering: strict program order; inst_pc increases by 4 between consecutive pops absent redirect.
//  Redirect has highest priority:
//   - A pop in the same cycle is honoured (handshake complete).
//   - The queue is flushed (count=0), there is no push that cycle, and inst_valid=0 next cycle.
//   - redirect_pc[1:0]==0 and redirect_pc < MEM_BYTES: fetch_pc <= redirect_pc, fault <= 0.
//     Target instruction becomes valid 2 cycles after the redirect edge.
//   - Otherwise: fault <= 1, fetch_pc unchanged, fetching stops.
//  Out of range: when fetch_pc reaches MEM_BYTES, fault <= 1 and pushing stops.
//   Entries already queued still drain normally.
//  fault clears only on reset or on a valid in-range aligned redirect.
//  No 32-bit PC wrap is possible (range check precedes increment).
//  States (derived, no explicit encoding required):
//   RUN    = !fault
//   FAULT  = fault
//   STALL  = RUN & full & !pop
//  Transitions: RUN->FAULT on bad redirect/range; FAULT->RUN on good redirect; any->RUN(reset) on rst.
// STRUCTURE
//  fetch_defs.vh (shared): INST_W=32, ADDR_W=32, WORD_BYTES=4, NOP=32'h0000_0000.
//   Also included by decode and the instruction memory.
//  Sub-module fetch_queue: synchronous FIFO, params WIDTH=64, DEPTH.
//   Ports: clk, rst, flush, push, push_data, pop, head_data, empty, full, count.
//   Flush has priority over push in the same cycle; pop with flush is a no-op.
//  Top level holds fetch_pc, fault and the push/redirect priority logic only.
// TESTING
//  1 Reset then inst_ready=1, memory preloaded word i = 32'h1000_0000+i:
//    cycle 2 -> inst_pc=0, inst_out=32'h1000_0000; each cycle after, inst_pc +4, one per cycle.
//  2 inst_ready=0 for 5 cycles: count saturates at 2, imem_addr holds at 8.
//    Release -> pops PC 0,4,8 back-to-back, no gaps or duplicates.
//  3 Redirect to 32'h40 while head=PC 8 and inst_ready=1:
//    PC 8 consumed, inst_valid=0 next cycle, next pop inst_pc=32'h40.
//  4 Redirect to 32'h42: fault=1, queue empty, no further pushes.
//    Redirect to 32'h10 -> fault=0, inst_pc=32'h10 delivered.
//  5 Redirect to 32'h3FC: pops PC 32'h3FC, then fault=1, inst_valid=0, imem_addr stays 32'h400.
//  6 Assert rst with queue full and fault=1:
//    next cycle inst_valid=0, fault=0, imem_addr=RESET_PC; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-path definitions: widths, queue entry layout, fetch state, target check.
// Used by the fetch unit, its queue and the decode/imem side of the interface.
package instruction_fetch_unit_pkg;

  localparam int INST_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [INST_W-1:0] NOP = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // A redirect target is usable only if word aligned and inside instruction memory.
  function automatic logic target_ok(input logic [ADDR_W-1:0] addr,
                                     input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) && (addr < mem_bytes);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: instruction memory port, redirect input, decode valid/ready and fault.
// master = fetch unit, slave = surrounding memory/decode logic.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              fault;

  modport master (
    output imem_addr, inst_valid, inst_out, inst_pc, fault,
    input  imem_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_addr, inst_valid, inst_out, inst_pc, fault,
    output imem_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, inst} entries; head is read combinationally.
// Latency 1 cycle push-to-head; flush beats push, pop is ignored on flush or when empty.
module instruction_fetch_unit_fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             do_push;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // When full, a push is legal only alongside a pop (the slot being freed).
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the fetch PC, drives instruction memory and queues {pc, inst} for decode.
// Head valid one cycle after fetch; stalls fetching while the queue is full and not popped.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_unit_if.master   bus
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;

  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic              q_empty;
  logic              q_full;
  logic [CNT_W-1:0]  q_count;
  logic              head_vld;
  logic              pop;
  logic              push;
  logic              in_range;

  assign head_vld   = ~q_empty;
  assign pop        = head_vld & bus.inst_ready;
  assign in_range   = (fetch_pc_q < MEM_BYTES);
  // Redirect owns the cycle: no fetch is queued while the queue is being flushed.
  assign push       = (state_q == ST_RUN) & ~bus.redirect_valid & in_range & (~q_full | pop);
  assign push_entry = '{pc: fetch_pc_q, inst: bus.imem_data};

  instruction_fetch_unit_fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      if (target_ok(bus.redirect_pc, MEM_BYTES)) begin
        state_d    = ST_RUN;
        fetch_pc_d = bus.redirect_pc;
      end else begin
        state_d    = ST_FAULT;
      end
    end else if (state_q == ST_RUN) begin
      // Range is checked before the increment, so the PC can never wrap.
      if (!in_range) begin
        state_d = ST_FAULT;
      end else if (push) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(WORD_BYTES);
      end
    end
  end

  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = head_vld;
  assign bus.inst_out   = head_vld ? head_entry.inst : NOP;
  assign bus.inst_pc    = head_vld ? head_entry.pc : '0;
  assign bus.fault      = (state_q == ST_FAULT);

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    q_count <= CNT_W'(QUEUE_DEPTH));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Fetch unit bench: directed scenarios plus randomized ready/redirect/reset traffic,
// every cycle compared against a queue-based reference model of the fetch rules.
module tb_instruction_fetch_unit;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int          DEPTH     = 2;

  logic clk;
  logic rst;
  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  logic        m_fault;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .MEM_BYTES   (MEM_BYTES),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr[9:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc    = 32'h0;
    m_fault = 1'b0;
  endtask

  task automatic check_model();
    logic        v;
    logic [63:0] h;
    v = (m_q.size() != 0);
    h = v ? m_q[0] : 64'h0;
    chk("m_valid", 32'(bus.inst_valid), 32'(v));
    chk("m_inst_pc", bus.inst_pc, h[63:32]);
    chk("m_inst_out", bus.inst_out, h[31:0]);
    chk("m_imem_addr", bus.imem_addr, m_pc);
    chk("m_fault", 32'(bus.fault), 32'(m_fault));
  endtask

  // Reference behaviour of one clock edge, written from the fetch rules.
  task automatic model_edge(input logic r, input logic ready, input logic rv,
                            input logic [31:0] rpc);
    bit do_pop;
    do_pop = (m_q.size() != 0) && ready;
    if (r) begin
      model_reset();
      return;
    end
    if (do_pop) void'(m_q.pop_front());
    if (rv) begin
      m_q.delete();
      if (rpc[1:0] == 2'b00 && rpc < MEM_BYTES) begin
        m_pc    = rpc;
        m_fault = 1'b0;
      end else begin
        m_fault = 1'b1;
      end
    end else if (!m_fault) begin
      if (m_pc >= MEM_BYTES) begin
        m_fault = 1'b1;
      end else if (m_q.size() < DEPTH) begin
        m_q.push_back({m_pc, word_at(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic r, input logic ready, input logic rv, input logic [31:0] rpc);
    rst                = r;
    bus.inst_ready     = ready;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    check_model();
    model_edge(r, ready, rv, rpc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        r_r;
    logic        r_ready;
    logic        r_rv;
    logic [31:0] r_pc;

    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

    rst                = 1'b1;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_out", bus.inst_out, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);

    // Streaming with decode always ready.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t1_valid", 32'(bus.inst_valid), 32'd1);
    chk("t1_pc0", bus.inst_pc, 32'h0);
    chk("t1_out0", bus.inst_out, 32'h1000_0000);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("t1_seq_pc", bus.inst_pc, 32'(4 * k));
      chk("t1_seq_out", bus.inst_out, 32'h1000_0000 + 32'(k));
    end

    // Backpressure: queue fills, fetch address holds.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t2_addr_hold", bus.imem_addr, 32'h8);
    chk("t2_valid", 32'(bus.inst_valid), 32'd1);
    for (int k = 0; k < 2; k++) begin
      chk("t2_drain_pc", bus.inst_pc, 32'(4 * k));
      step(1'b0, 1'b1, 1'b0, 32'h0);
    end
    chk("t2_drain_pc", bus.inst_pc, 32'h8);

    // Redirect while popping PC 8.
    step(1'b0, 1'b1, 1'b1, 32'h40);
    chk("t3_flush_valid", 32'(bus.inst_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t3_target_valid", 32'(bus.inst_valid), 32'd1);
    chk("t3_target_pc", bus.inst_pc, 32'h40);

    // Misaligned redirect faults, good redirect recovers.
    step(1'b0, 1'b1, 1'b1, 32'h42);
    chk("t4_fault", 32'(bus.fault), 32'd1);
    chk("t4_valid", 32'(bus.inst_valid), 32'd0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4_stopped_valid", 32'(bus.inst_valid), 32'd0);
    chk("t4_stopped_addr", bus.imem_addr, 32'h44);
    step(1'b0, 1'b1, 1'b1, 32'h10);
    chk("t4_fault_clear", 32'(bus.fault), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4_recover_pc", bus.inst_pc, 32'h10);

    // Last word of memory, then out-of-range fault.
    step(1'b0, 1'b1, 1'b1, 32'h3FC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_last_pc", bus.inst_pc, 32'h3FC);
    chk("t5_no_fault_yet", 32'(bus.fault), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_fault", 32'(bus.fault), 32'd1);
    chk("t5_valid", 32'(bus.inst_valid), 32'd0);
    chk("t5_addr", bus.imem_addr, 32'h400);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_addr_hold", bus.imem_addr, 32'h400);

    // Reset with a full queue while faulted.
    step(1'b0, 1'b0, 1'b1, 32'h3F8);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_pre_fault", 32'(bus.fault), 32'd1);
    chk("t6_pre_valid", 32'(bus.inst_valid), 32'd1);
    chk("t6_pre_head", bus.inst_pc, 32'h3F8);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t6_valid", 32'(bus.inst_valid), 32'd0);
    chk("t6_fault", 32'(bus.fault), 32'd0);
    chk("t6_addr", bus.imem_addr, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t6_resume_pc", bus.inst_pc, 32'h0);
    chk("t6_resume_valid", 32'(bus.inst_valid), 32'd1);

    // Randomized traffic against the model.
    repeat (800) begin
      r_r     = ($urandom_range(99) == 0);
      r_ready = ($urandom_range(9) < 7);
      r_rv    = ($urandom_range(14) == 0);
      case ($urandom_range(7))
        0, 1, 2, 3: r_pc = $urandom_range(255) << 2;
        4:          r_pc = 32'h3F0 + ($urandom_range(3) << 2);
        5:          r_pc = ($urandom_range(255) << 2) | $urandom_range(3, 1);
        6:          r_pc = 32'h400 + ($urandom_range(63) << 2);
        default:    r_pc = $urandom;
      endcase
      step(r_r, r_ready, r_rv, r_pc);
    end
    #1;
    check_model();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
